// File: rtl/sevenseg_ctrl_pkg.sv
// Shared definitions for the four-digit seven-segment controller:
// bus register addresses, scanner states and active-low segment patterns.
package sevenseg_ctrl_pkg;

  localparam logic [1:0] ADDR_VAL_LO = 2'd0;
  localparam logic [1:0] ADDR_VAL_HI = 2'd1;
  localparam logic [1:0] ADDR_MASK   = 2'd2;
  localparam logic [1:0] ADDR_CTRL   = 2'd3;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } scan_state_t;

  // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

endpackage

// File: rtl/sevenseg_ctrl_hex7seg.sv
// Combinational hex nibble to active-low seven-segment pattern decoder.
module hex7seg
  import sevenseg_ctrl_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Plain lookup of the sixteen hex glyphs.
  always_comb begin
    seg = SEG_BLANK;
    case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/sevenseg_ctrl.sv
// Four-digit multiplexed seven-segment controller with a small register bus.
// Each digit slot is REFRESH_DIV cycles: BLANK_CYCLES with all anodes off,
// then the digit is driven for the rest of the slot.
module sevenseg_ctrl
  import sevenseg_ctrl_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cs,
  input  logic       we,
  input  logic [1:0] addr,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic [6:0] segments,
  output logic       decimal_point,
  output logic [3:0] anode
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0] BLANK_LAST = PW'(BLANK_CYCLES - 1);
  localparam logic [PW-1:0] SLOT_LAST  = PW'(REFRESH_DIV - 1);

  logic [7:0]  shadow_lo_reg;
  logic [15:0] value_reg;
  logic [7:0]  mask_reg;
  logic [1:0]  ctrl_reg;
  logic [7:0]  data_out_reg;

  scan_state_t state_reg;
  logic [PW-1:0] presc_reg;
  logic [1:0]    idx_reg;
  logic [3:0]    anode_reg;
  logic [6:0]    segments_reg;
  logic          dp_reg;

  logic       wr_en;
  logic       enable_next;
  logic [3:0] upper_zero;
  logic [3:0] digit_blank;
  logic [3:0] dp_mask;
  logic [3:0] cur_nibble;
  logic [6:0] hex_seg;

  assign wr_en = cs && we;
  // The scanner reacts to an enable write on the same edge it lands.
  assign enable_next = (wr_en && (addr == ADDR_CTRL)) ? data_in[0] : ctrl_reg[0];
  assign dp_mask     = mask_reg[3:0];
  assign cur_nibble  = value_reg[{idx_reg, 2'b00} +: 4];

  // Per-digit blanking: forced by mask, or a leading zero above digit 0.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
      assign upper_zero[gi]  = (value_reg[15:4*gi] == '0);
      assign digit_blank[gi] = mask_reg[4+gi] | ((gi != 0) & ctrl_reg[1] & upper_zero[gi]);
    end
  endgenerate

  hex7seg u_hex7seg (
    .nibble (cur_nibble),
    .seg    (hex_seg)
  );

  // Bus register file; writing the high byte commits the shadowed low byte.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      shadow_lo_reg <= 8'h00;
      value_reg     <= 16'h0000;
      mask_reg      <= 8'h00;
      ctrl_reg      <= 2'b00;
    end else if (wr_en) begin
      case (addr)
        ADDR_VAL_LO: shadow_lo_reg <= data_in;
        ADDR_VAL_HI: value_reg     <= {data_in, shadow_lo_reg};
        ADDR_MASK:   mask_reg      <= data_in;
        ADDR_CTRL:   ctrl_reg      <= data_in[1:0];
        default:     ;
      endcase
    end
  end

  // Registered read port; holds its value unless a read is issued.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_out_reg <= 8'h00;
    end else if (cs && !we) begin
      case (addr)
        ADDR_VAL_LO: data_out_reg <= shadow_lo_reg;
        ADDR_VAL_HI: data_out_reg <= value_reg[15:8];
        ADDR_MASK:   data_out_reg <= mask_reg;
        ADDR_CTRL:   data_out_reg <= {6'b000000, ctrl_reg};
        default:     data_out_reg <= 8'h00;
      endcase
    end
  end

  // Scanner FSM plus display output registers, which follow the current state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg    <= ST_OFF;
      presc_reg    <= '0;
      idx_reg      <= 2'd0;
      anode_reg    <= 4'b1111;
      segments_reg <= SEG_BLANK;
      dp_reg       <= 1'b1;
    end else begin
      if (!enable_next) begin
        state_reg <= ST_OFF;
        presc_reg <= '0;
        idx_reg   <= 2'd0;
      end else begin
        case (state_reg)
          ST_OFF: begin
            state_reg <= ST_BLANK;
            presc_reg <= '0;
            idx_reg   <= 2'd0;
          end
          ST_BLANK: begin
            if (presc_reg == BLANK_LAST) state_reg <= ST_DRIVE;
            presc_reg <= presc_reg + 1'b1;
          end
          ST_DRIVE: begin
            if (presc_reg == SLOT_LAST) begin
              state_reg <= ST_BLANK;
              presc_reg <= '0;
              idx_reg   <= idx_reg + 2'd1;
            end else begin
              presc_reg <= presc_reg + 1'b1;
            end
          end
          default: begin
            state_reg <= ST_OFF;
            presc_reg <= '0;
            idx_reg   <= 2'd0;
          end
        endcase
      end

      if (state_reg == ST_DRIVE) begin
        anode_reg    <= ~(4'b0001 << idx_reg);
        segments_reg <= digit_blank[idx_reg] ? SEG_BLANK : hex_seg;
        dp_reg       <= ~dp_mask[idx_reg];
      end else begin
        anode_reg    <= 4'b1111;
        segments_reg <= SEG_BLANK;
        dp_reg       <= 1'b1;
      end
    end
  end

  assign data_out      = data_out_reg;
  assign anode         = anode_reg;
  assign segments      = segments_reg;
  assign decimal_point = dp_reg;

endmodule

// File: tb/tb_sevenseg_ctrl.sv
// Scoreboard bench for sevenseg_ctrl with REFRESH_DIV=8, BLANK_CYCLES=2.
// Stimulus pushes expected digit slots and read data into queues; a monitor
// pops and compares whenever a slot finishes or read data is presented.
module tb_sevenseg_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       cs = 1'b0;
  logic       we = 1'b0;
  logic [1:0] addr = 2'd0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic [6:0] segments;
  logic       decimal_point;
  logic [3:0] anode;

  always #5 clk = ~clk;

  sevenseg_ctrl #(.REFRESH_DIV(8), .BLANK_CYCLES(2)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .cs            (cs),
    .we            (we),
    .addr          (addr),
    .data_in       (data_in),
    .data_out      (data_out),
    .segments      (segments),
    .decimal_point (decimal_point),
    .anode         (anode)
  );

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    int         len;
  } slot_t;

  slot_t      slot_q[$];
  logic [7:0] rd_q[$];
  int         checks = 0;
  int         failures = 0;
  logic       rd_pending = 1'b0;
  logic       mon_en = 1'b0;

  // A read issued on this edge shows up on data_out just after it.
  always @(posedge clk) rd_pending <= cs && !we && reset_n;

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end else begin
      $display("check %s = %h ok", name, got);
    end
  endtask

  // Monitor: read data and completed digit slots.
  initial begin
    slot_t cur;
    slot_t e;
    logic [7:0] rexp;
    bit in_slot;
    in_slot = 0;
    cur = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, len: 0};
    forever begin
      @(negedge clk);
      if (rd_pending) begin
        checks++;
        if (rd_q.size() == 0) begin
          failures++;
          $display("FAIL read_unexpected got=%h expected=none", data_out);
        end else begin
          rexp = rd_q.pop_front();
          if (data_out !== rexp) begin
            failures++;
            $display("FAIL read got=%h expected=%h", data_out, rexp);
          end else begin
            $display("read data=%h ok", data_out);
          end
        end
      end
      if (!mon_en) begin
        in_slot = 0;
      end else if (in_slot && anode === cur.an && segments === cur.seg && decimal_point === cur.dp) begin
        cur.len++;
      end else begin
        if (in_slot) begin
          checks++;
          if (slot_q.size() == 0) begin
            failures++;
            $display("FAIL slot_unexpected got an=%b seg=%b dp=%b len=%0d", cur.an, cur.seg, cur.dp, cur.len);
          end else begin
            e = slot_q.pop_front();
            if (cur.an !== e.an || cur.seg !== e.seg || cur.dp !== e.dp || cur.len != e.len) begin
              failures++;
              $display("FAIL slot got an=%b seg=%b dp=%b len=%0d expected an=%b seg=%b dp=%b len=%0d",
                       cur.an, cur.seg, cur.dp, cur.len, e.an, e.seg, e.dp, e.len);
            end else begin
              $display("slot an=%b seg=%b dp=%b len=%0d ok", cur.an, cur.seg, cur.dp, cur.len);
            end
          end
          in_slot = 0;
        end
        if (anode !== 4'hF) begin
          cur = '{an: anode, seg: segments, dp: decimal_point, len: 1};
          in_slot = 1;
        end
      end
    end
  end

  // Tasks are entered just after a falling edge; the bus edge is the next rising edge.
  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    cs = 1'b1; we = 1'b1; addr = a; data_in = d;
    @(negedge clk);
    cs = 1'b0; we = 1'b0;
    #1;
  endtask

  task automatic rd(input logic [1:0] a, input logic [7:0] exp);
    rd_q.push_back(exp);
    cs = 1'b1; we = 1'b0; addr = a;
    @(negedge clk);
    cs = 1'b0;
    #1;
  endtask

  task automatic exp_slot(input int digit, input logic [6:0] seg, input logic dp, input int len);
    slot_t s;
    logic [3:0] an;
    an = 4'b1111;
    an[digit] = 1'b0;
    s = '{an: an, seg: seg, dp: dp, len: len};
    slot_q.push_back(s);
  endtask

  task automatic exp_round(input logic [6:0] s0, input logic [6:0] s1,
                           input logic [6:0] s2, input logic [6:0] s3);
    exp_slot(0, s0, 1'b1, 6);
    exp_slot(1, s1, 1'b1, 6);
    exp_slot(2, s2, 1'b1, 6);
    exp_slot(3, s3, 1'b1, 6);
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while ((slot_q.size() > 0 || rd_q.size() > 0) && t < 400) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (slot_q.size() > 0 || rd_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout got=%0d_pending expected=0", name, slot_q.size() + rd_q.size());
      slot_q.delete();
      rd_q.delete();
    end
  endtask

  initial begin
    int lat;
    int t;

    // Reset state
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_anode", 16'(anode), 16'h000F);
    chk("reset_segments", 16'(segments), 16'h007F);
    chk("reset_dp", 16'(decimal_point), 16'h0001);
    chk("reset_data_out", 16'(data_out), 16'h0000);
    reset_n = 1'b1;
    #1;
    for (int a = 0; a < 4; a++) rd(2'(a), 8'h00);
    drain("reset_reads");

    // Basic scan of 1234, two full rounds to cover digit wrap
    wr(2'd0, 8'h34);
    wr(2'd1, 8'h12);
    exp_round(7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001);
    exp_round(7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001);
    mon_en = 1'b1;
    wr(2'd3, 8'h01);
    drain("scan_1234");
    wr(2'd3, 8'h00);
    mon_en = 1'b0;

    // Shadow low byte does not change display until the high byte commits
    wr(2'd0, 8'h78);
    rd(2'd0, 8'h78);
    rd(2'd1, 8'h12);
    exp_round(7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001);
    mon_en = 1'b1;
    wr(2'd3, 8'h01);
    drain("shadow_1234");
    exp_round(7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010);
    wr(2'd1, 8'h56);
    drain("commit_5678");
    wr(2'd3, 8'h00);
    mon_en = 1'b0;

    // Leading-zero blanking on 0005, then plain zeros with it disabled
    wr(2'd0, 8'h05);
    wr(2'd1, 8'h00);
    exp_round(7'b0010010, 7'h7F, 7'h7F, 7'h7F);
    mon_en = 1'b1;
    wr(2'd3, 8'h03);
    drain("lzb_0005");
    exp_round(7'b0010010, 7'b1000000, 7'b1000000, 7'b1000000);
    wr(2'd3, 8'h01);
    drain("nolzb_0005");
    wr(2'd3, 8'h00);
    mon_en = 1'b0;

    // Leading-zero blanking stops at the highest non-zero nibble: 0105
    wr(2'd0, 8'h05);
    wr(2'd1, 8'h01);
    exp_round(7'b0010010, 7'b1000000, 7'b1111001, 7'h7F);
    mon_en = 1'b1;
    wr(2'd3, 8'h03);
    drain("lzb_0105");
    wr(2'd3, 8'h00);
    mon_en = 1'b0;

    // Upper CTRL bits read back as zero
    wr(2'd3, 8'hFC);
    rd(2'd3, 8'h00);
    drain("ctrl_upper");

    // MASK: dp on digit 0, force-blank digit 1
    wr(2'd0, 8'h34);
    wr(2'd1, 8'h12);
    wr(2'd2, 8'h21);
    exp_slot(0, 7'b0011001, 1'b0, 6);
    exp_slot(1, 7'h7F, 1'b1, 6);
    exp_slot(2, 7'b0100100, 1'b1, 6);
    exp_slot(3, 7'b1111001, 1'b1, 6);
    mon_en = 1'b1;
    wr(2'd3, 8'h01);
    rd(2'd2, 8'h21);
    rd(2'd3, 8'h01);
    drain("mask_21");
    wr(2'd3, 8'h00);
    mon_en = 1'b0;

    // Disable mid-DRIVE of digit 2, then re-enable
    wr(2'd2, 8'h00);
    exp_slot(0, 7'b0011001, 1'b1, 6);
    exp_slot(1, 7'b0110000, 1'b1, 6);
    exp_slot(2, 7'b0100100, 1'b1, 2);
    mon_en = 1'b1;
    wr(2'd3, 8'h01);
    t = 0;
    while (anode !== 4'b1011 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("reach_digit2", 16'(anode), 16'h000B);
    #1;
    wr(2'd3, 8'h00);
    drain("disable_mid");
    chk("off_anode", 16'(anode), 16'h000F);
    exp_slot(0, 7'b0011001, 1'b1, 6);
    wr(2'd3, 8'h01);
    lat = 0;
    while (anode === 4'hF && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("reenable_latency", 16'(lat), 16'd3);
    chk("reenable_digit0", 16'(anode), 16'h000E);
    #1;
    drain("reenable");
    wr(2'd3, 8'h00);
    mon_en = 1'b0;

    // Reset mid-slot concurrent with a VAL_HI write
    wr(2'd0, 8'hAA);
    wr(2'd1, 8'hBB);
    wr(2'd2, 8'h0F);
    wr(2'd3, 8'h03);
    t = 0;
    while (anode === 4'hF && t < 100) begin
      @(negedge clk);
      t++;
    end
    #1;
    reset_n = 1'b0;
    cs = 1'b1; we = 1'b1; addr = 2'd1; data_in = 8'hFF;
    @(negedge clk);
    cs = 1'b0; we = 1'b0;
    chk("rst_anode", 16'(anode), 16'h000F);
    chk("rst_segments", 16'(segments), 16'h007F);
    chk("rst_dp", 16'(decimal_point), 16'h0001);
    chk("rst_data_out", 16'(data_out), 16'h0000);
    #1;
    reset_n = 1'b1;
    for (int a = 0; a < 4; a++) rd(2'(a), 8'h00);
    drain("rst_reads");
    repeat (10) @(negedge clk);
    chk("rst_stays_off", 16'(anode), 16'h000F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sevenseg_ctrl.md
SEVENSEG_CTRL -- requirements
Module: sevenseg_ctrl

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000: clk cycles per digit slot; legal range 4..2^20.
REQ-002 SHALL have parameter BLANK_CYCLES, default 1000: cycles per slot with all anodes off (anti-ghost); legal range 1..REFRESH_DIV-2.
REQ-003 SHALL have port clk  in  1  system clock; all logic on rising edge.
REQ-004 SHALL have port reset_n  in  1  synchronous, active-low reset.
REQ-005 SHALL have port cs  in  1  bus chip select.
REQ-006 SHALL have port we  in  1  write strobe; qualified by cs.
REQ-007 SHALL have port addr  in  2  register select.
REQ-008 SHALL have port data_in  in  8  write data.
REQ-009 SHALL have port data_out  out  8  registered read data.
REQ-010 SHALL have port segments  out  7  {g,f,e,d,c,b,a}, active-low.
REQ-011 SHALL have port decimal_point  out  1  active-low.
REQ-012 SHALL have port anode  out  4  digit enables, active-low; bit i = digit i, digit 0 rightmost.

Function
REQ-013 Register map SHALL be: 0 VAL_LO (shadow, digits 1:0); 1 VAL_HI (digits 3:2, commit); 2 MASK (bits 3:0 dp on, bits 7:4 digit force-blank); 3 CTRL (bit0 enable, bit1 leading-zero blank, bits 7:2 read 0).
REQ-014 Write to addr 0 SHALL update only the shadow low byte; displayed value unchanged.
REQ-015 Write to addr 1 SHALL atomically load displayed value = {data_in, shadow_lo} on the same edge.
REQ-016 Read (cs=1, we=0) SHALL return the addressed register on data_out one cycle later; addr 0 returns shadow, addr 1 returns displayed high byte; data_out holds its value when cs=0.
REQ-017 Scanner states SHALL be OFF, BLANK, DRIVE; prescaler counts 0..REFRESH_DIV-1 per slot.
REQ-018 OFF: enable=0; anode=4'b1111, segments=7'h7F, decimal_point=1; prescaler and digit index held at 0.
REQ-019 OFF->BLANK on enable 0->1; slot starts at digit 0, prescaler 0.
REQ-020 BLANK->DRIVE when prescaler = BLANK_CYCLES-1; DRIVE->BLANK when prescaler = REFRESH_DIV-1, digit index advancing 0->1->2->3->0 (wrap) and prescaler returning to 0.
REQ-021 Any state->OFF on the edge where enable is written 0.
REQ-022 DRIVE SHALL assert only anode[idx]=0, drive hex decode of the current nibble and decimal_point = ~MASK[idx].
REQ-023 Hex decode SHALL map 0->1000000, 1->1111001, 2->0100100, 3->0110000, 4->0011001, 5->0010010, 6->0000010, 7->1111000, 8->0000000, 9->0010000, A->0001000, b->0000011, C->1000110, d->0100001, E->0000110, F->0001110.
REQ-024 A digit SHALL be blanked (segments=7'h7F; anode still driven; dp still honoured) if MASK[4+idx]=1, or CTRL[1]=1, idx!=0, and nibbles idx..3 all zero.
REQ-025 All outputs SHALL be registered: anode/segments/decimal_point reflect state and register contents one cycle after the edge that changes them.
REQ-026 Register writes mid-slot SHALL take effect on the next cycle without disturbing prescaler or digit index.

Reset
REQ-027 On clk edge with reset_n=0: state OFF, all registers and shadow 0, prescaler 0, index 0, data_out 8'h00, anode 4'b1111, segments 7'h7F, decimal_point 1.
REQ-028 Reset mid-slot SHALL override any concurrent bus write.

Structure
REQ-029 Shared package SHALL hold register address constants, scanner state enumeration, and segment pattern constants.
REQ-030 Hex decode SHALL be sub-module hex7seg (4-bit nibble in, 7-bit active-low pattern out, combinational).

Verification (REFRESH_DIV=8, BLANK_CYCLES=2)
REQ-031 Reset, then write VAL_LO=34, VAL_HI=12, CTRL=01 -> anode cycles 1110,1101,1011,0111, each low 6 of 8 cycles; segments 0011001,0110000,0100100,1111001.
REQ-032 Write VAL_LO=78 only, read addr 0 and 1 -> display still 1234; reads return 78 and 12; then write VAL_HI=56 -> display 5678 next cycle.
REQ-033 Value 0005, CTRL=03 -> digits 3..1 segments 7F, digit 0 = 0010010; CTRL=01 -> digits show 1000000.
REQ-034 MASK=8'h21 -> digit 0 decimal_point=0, digit 1 segments 7F; others normal.
REQ-035 Write CTRL=00 mid-DRIVE of digit 2 -> next cycle anode 1111; re-enable -> first DRIVE on digit 0 after 2 blank cycles.
REQ-036 Assert reset_n=0 concurrent with write VAL_HI=FF -> all registers 0, outputs at reset values.
